sprite_loader: RTL and testbench
================================

Name: sprite_loader

Overview:
Writer side of the sprite bitmap path. Accepts a byte stream over a valid/ready handshake and packs it into 16 lines of 64-bit RGBA words, in the same layout the sprite draw logic consumes. Stores the sprite in a double-buffered line RAM. Swaps banks only on a frame sync, so the display never shows a half-loaded sprite.

Parameters:
LINES, 16, sprite lines per bank; line index width is log2(LINES).
LINE_BITS, 64, bits per line (16 pixels x 4 bits RGBA).
BYTES_PER_LINE, LINE_BITS/8 (8), derived; not overridable.

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
in_data  in  8  two pixels; high nibble = left pixel
in_valid  in  1  in_data valid
in_sof  in  1  marks in_data as byte 0 of a sprite; qualified by in_valid
in_ready  out  1  loader can accept a byte this cycle
frame_sync  in  1  one-cycle pulse at vertical blank; bank swap point
rd_line  in  4  line index from the draw logic
rd_bits  out  64  display-bank line; combinational from rd_line
busy  out  1  high in LOAD or PENDING
loaded  out  1  one-cycle pulse on the cycle the new bank becomes visible
sync_err  out  1  one-cycle pulse on a framing error

Behaviour:
- Handshake: a byte is accepted when in_valid && in_ready at the clk edge. in_ready = 1 in IDLE and LOAD, 0 in PENDING.
- Pixel layout:
  - Pixel p of a line occupies bits[63-4p : 60-4p].
  - Within a nibble: bit0 = R, bit1 = G, bit2 = B, bit3 = A.
  - Accepted byte k of a line (k = 0..7) lands in bits[63-8k : 56-8k].
- FSM states IDLE, LOAD, PENDING:
  - IDLE: a byte accepted with in_sof=1 becomes byte 0, and the state goes to LOAD. A byte accepted with in_sof=0 is discarded and pulses sync_err.
  - LOAD: each accepted byte is shifted into a 64-bit assembly register.
    - On the 8th byte of a line, the full word is written to the back bank at line_cnt, and line_cnt increments.
    - On acceptance of byte 127 (the last byte of line 15), the state goes to PENDING.
  - LOAD with an accepted in_sof=1: sync_err pulses, counters restart, and that byte is taken as byte 0. Lines already written to the back bank are overwritten by the new load.
  - PENDING: on frame_sync=1, bank_sel toggles at that edge. The back bank's valid flag is set, loaded pulses in the following cycle, and the state returns to IDLE.
- frame_sync while in IDLE or LOAD is ignored. frame_sync in the same cycle as the final byte does not swap; the swap waits for the next frame_sync.
- Read side:
  - rd_bits = bank[bank_sel][rd_line] when that bank's valid flag is set, else 64'h0 (fully transparent).
  - Zero-latency combinational read. It reflects the new bank in the cycle after the swap edge.
- Reset values:
  - state = IDLE; counters = 0; bank_sel = 0; both valid flags = 0.
  - in_ready = 1; busy = 0; loaded = 0; sync_err = 0; rd_bits = 0.
  - RAM contents are not reset.
- Reset mid-load or in PENDING: the partial load is abandoned and no swap occurs. Display goes transparent until a complete sprite has been loaded and swapped in.
- Width rules:
  - Byte counter is 3 bits; it wraps 7 -> 0 on each line write.
  - Line counter is 4 bits; it reaches 15 and is not incremented past the final write.

Decomposition:
- Shared package holds:
  - SPRITE_LINES = 16, SPRITE_LINE_BITS = 64, SPRITE_BYTES_PER_LINE = 8.
  - Nibble bit positions: RGBA_R = 0, RGBA_G = 1, RGBA_B = 2, RGBA_A = 3.
  - The FSM state encoding: IDLE = 0, LOAD = 1, PENDING = 2.
- One sub-module: sprite_line_ram, a 2 x 16 x 64 RAM with a synchronous write port (bank, line, data, we) and an asynchronous read port (bank, line). It is instantiated once; the loader owns bank_sel and the valid flags.

Test Plan:
- Reset, then check outputs → rd_bits = 0 for all rd_line; in_ready = 1; busy = 0; loaded = 0.
- Load 128 bytes with in_sof on byte 0, bytes = index value (0x00..0x7F), then pulse frame_sync → loaded pulses once. Line 0 reads 64'h0001020304050607; line 15 reads 64'h78797A7B7C7D7E7F.
- After a load, before frame_sync → rd_bits still shows the old bank; in_ready = 0 and busy = 1 in PENDING. frame_sync in the same cycle as byte 127 → no swap until the next frame_sync.
- Stray byte 0xFF in IDLE without in_sof → sync_err pulses, byte discarded. A subsequent clean 128-byte load displays correctly.
- in_sof reasserted at byte 40 of a load, then a full 128 bytes of 0x11 → one sync_err pulse. After frame_sync every line reads 64'h1111111111111111.
- Assert reset while in PENDING → after release rd_bits = 0 and no loaded pulse; in_valid toggled randomly never accepts a byte while in_ready = 0.

Source files
------------

// File: rtl/sprite_loader_pkg.sv
// sprite_loader_pkg: shared sprite geometry, RGBA nibble bit positions and loader FSM encoding
package sprite_loader_pkg;
  localparam int SPRITE_LINES = 16;
  localparam int SPRITE_LINE_BITS = 64;
  localparam int SPRITE_BYTES_PER_LINE = SPRITE_LINE_BITS / 8;
  localparam int RGBA_R = 0;
  localparam int RGBA_G = 1;
  localparam int RGBA_B = 2;
  localparam int RGBA_A = 3;
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    PENDING = 2'd2
  } state_t;
endpackage

// File: rtl/sprite_line_ram.sv
// sprite_line_ram: two banks of sprite lines, synchronous write and asynchronous read
module sprite_line_ram
  import sprite_loader_pkg::*;
#(
  parameter int LINES = SPRITE_LINES,
  parameter int LINE_BITS = SPRITE_LINE_BITS
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic                     wr_bank,
  input  logic [$clog2(LINES)-1:0] wr_line,
  input  logic [LINE_BITS-1:0]     wr_data,
  input  logic                     rd_bank,
  input  logic [$clog2(LINES)-1:0] rd_line,
  output logic [LINE_BITS-1:0]     rd_data
);
  logic [LINE_BITS-1:0] mem [2][LINES];
  // contents are deliberately left unreset; the loader's valid flags mask stale data
  always_ff @(posedge clk) begin
    if (we) mem[wr_bank][wr_line] <= wr_data;
  end
  assign rd_data = mem[rd_bank][rd_line];
endmodule

// File: rtl/sprite_loader.sv
// sprite_loader: packs a byte stream into a double-buffered sprite line RAM, swapping banks on frame sync
module sprite_loader
  import sprite_loader_pkg::*;
#(
  parameter int LINES = SPRITE_LINES,
  parameter int LINE_BITS = SPRITE_LINE_BITS
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [7:0]               in_data,
  input  logic                     in_valid,
  input  logic                     in_sof,
  output logic                     in_ready,
  input  logic                     frame_sync,
  input  logic [$clog2(LINES)-1:0] rd_line,
  output logic [LINE_BITS-1:0]     rd_bits,
  output logic                     busy,
  output logic                     loaded,
  output logic                     sync_err
);
  localparam int BYTES_PER_LINE = LINE_BITS / 8;
  localparam int LW = $clog2(LINES);
  localparam int BW = $clog2(BYTES_PER_LINE);
  state_t state, state_next;
  logic [BW-1:0] byte_cnt;
  logic [LW-1:0] line_cnt;
  logic [LINE_BITS-9:0] asm_reg;
  logic bank_sel;
  logic [1:0] valid;
  logic accept, we, restart, err, swap;
  logic [LINE_BITS-1:0] ram_rd;
  assign in_ready = state != PENDING;
  assign busy = state != IDLE;
  assign accept = in_valid && in_ready;
  // next state plus the per-cycle strobes that steer the datapath
  always_comb begin
    state_next = state;
    we = 1'b0;
    restart = 1'b0;
    err = 1'b0;
    swap = 1'b0;
    case (state)
      IDLE: begin
        restart = accept && in_sof;
        err = accept && !in_sof;
        state_next = restart ? LOAD : IDLE;
      end
      LOAD: begin
        restart = accept && in_sof;
        err = restart;
        we = accept && !in_sof && byte_cnt == BW'(BYTES_PER_LINE - 1);
        state_next = (we && line_cnt == LW'(LINES - 1)) ? PENDING : LOAD;
      end
      PENDING: begin
        swap = frame_sync;
        state_next = frame_sync ? IDLE : PENDING;
      end
      default: state_next = IDLE;
    endcase
  end
  // state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else state <= state_next;
  end
  // byte assembly, line counting, bank selection and status pulses
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      byte_cnt <= '0;
      line_cnt <= '0;
      asm_reg <= '0;
      bank_sel <= 1'b0;
      valid <= 2'b00;
      loaded <= 1'b0;
      sync_err <= 1'b0;
    end else begin
      loaded <= swap;
      sync_err <= err;
      if (restart) begin
        asm_reg <= (LINE_BITS - 8)'(in_data);
        byte_cnt <= BW'(1);
        line_cnt <= '0;
      end else if (accept && state == LOAD) begin
        asm_reg <= {asm_reg[LINE_BITS-17:0], in_data};
        byte_cnt <= byte_cnt + 1'b1;
        if (we && line_cnt != LW'(LINES - 1)) line_cnt <= line_cnt + 1'b1;
      end
      if (swap) begin
        bank_sel <= ~bank_sel;
        valid[~bank_sel] <= 1'b1;
      end
    end
  end
  sprite_line_ram #(.LINES(LINES), .LINE_BITS(LINE_BITS)) u_ram (
    .clk(clk),
    .we(we),
    .wr_bank(~bank_sel),
    .wr_line(line_cnt),
    .wr_data({asm_reg, in_data}),
    .rd_bank(bank_sel),
    .rd_line(rd_line),
    .rd_data(ram_rd)
  );
  assign rd_bits = valid[bank_sel] ? ram_rd : '0;
endmodule

// File: tb/tb_sprite_loader.sv
// tb_sprite_loader: randomized scoreboard bench for sprite_loader against a sprite-level reference model
`timescale 1ns/1ps
module tb_sprite_loader;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [7:0] in_data = '0;
  logic in_valid = 1'b0;
  logic in_sof = 1'b0;
  logic frame_sync = 1'b0;
  logic [3:0] rd_line = '0;
  logic in_ready, busy, loaded, sync_err;
  logic [63:0] rd_bits;

  sprite_loader dut (
    .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid), .in_sof(in_sof),
    .in_ready(in_ready), .frame_sync(frame_sync), .rd_line(rd_line), .rd_bits(rd_bits),
    .busy(busy), .loaded(loaded), .sync_err(sync_err)
  );

  always #50 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct packed { int cyc; logic r; logic b; } st_t;
  typedef struct packed { int cyc; logic [15:0][63:0] lines; } snap_t;
  st_t stq[$];
  snap_t snap_q[$];
  int loaded_q[$];
  int err_q[$];
  int checks = 0;
  int errors = 0;

  // reference model: a sprite is 128 bytes; a completed sprite replaces the back bank wholesale
  int phase = 0;
  int idx = 0;
  logic [7:0] ld_b [128];
  logic [7:0] mbank [2][128];
  bit msel = 0;
  bit mvalid [2] = '{0, 0};
  logic [7:0] spr [128];

  function automatic void chk(string n, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", n, act, exp, cyc);
    end
  endfunction

  function automatic logic [63:0] line_of(int b, int l);
    logic [63:0] w = '0;
    for (int k = 0; k < 8; k++) w = (w << 8) | 64'(mbank[b][8*l+k]);
    return w;
  endfunction

  function automatic void push_snap(int c);
    snap_t s;
    s.cyc = c;
    for (int l = 0; l < 16; l++) s.lines[l] = mvalid[msel] ? line_of(int'(msel), l) : 64'h0;
    snap_q.push_back(s);
  endfunction

  function automatic void model_step(logic v, logic s, logic [7:0] d, logic fs);
    st_t st;
    st.cyc = cyc;
    st.r = phase != 2;
    st.b = phase != 0;
    stq.push_back(st);
    if (phase == 2) begin
      if (fs) begin
        msel = ~msel;
        mvalid[msel] = 1;
        phase = 0;
        loaded_q.push_back(cyc + 1);
        push_snap(cyc + 1);
      end
    end else if (v) begin
      if (s) begin
        if (phase == 1) err_q.push_back(cyc + 1);
        ld_b[0] = d;
        idx = 1;
        phase = 1;
      end else if (phase == 0) begin
        err_q.push_back(cyc + 1);
      end else begin
        ld_b[idx] = d;
        idx++;
        if (idx == 128) begin
          phase = 2;
          for (int i = 0; i < 128; i++) mbank[msel ? 0 : 1][i] = ld_b[i];
        end
      end
    end
  endfunction

  task automatic cycle(input logic v, input logic s, input logic [7:0] d, input logic fs);
    in_valid = v;
    in_sof = s;
    in_data = d;
    frame_sync = fs;
    model_step(v, s, d, fs);
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 1'($urandom_range(0, 1)), 8'($urandom), 1'b0);
  endtask

  task automatic load(input int n, input bit fs_last);
    for (int i = 0; i < n; i++) begin
      while ($urandom_range(0, 3) == 0)
        cycle(1'b0, 1'($urandom_range(0, 1)), 8'($urandom), $urandom_range(0, 7) == 0);
      cycle(1'b1, i == 0, spr[i], fs_last && i == n - 1);
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    in_valid = 1'b0;
    frame_sync = 1'b0;
    phase = 0;
    idx = 0;
    msel = 0;
    mvalid = '{0, 0};
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    push_snap(cyc);
  endtask

  task automatic rand_sprite();
    for (int i = 0; i < 128; i++) spr[i] = 8'($urandom);
  endtask

  // monitor: compares DUT outputs against queued expectations at the falling edge
  initial begin
    st_t st;
    snap_t sn;
    forever begin
      @(negedge clk);
      if (reset) continue;
      if (stq.size() != 0 && stq[0].cyc == cyc) begin
        st = stq.pop_front();
        chk("in_ready", 64'(in_ready), 64'(st.r));
        chk("busy", 64'(busy), 64'(st.b));
      end
      while (loaded_q.size() != 0 && loaded_q[0] < cyc) begin
        checks++;
        errors++;
        $display("FAIL loaded_missing: no pulse, required at cycle %0d", loaded_q.pop_front());
      end
      if (loaded) begin
        if (loaded_q.size() == 0) chk("loaded_unexpected", 64'(loaded), 64'd0);
        else chk("loaded_cycle", 64'(cyc), 64'(loaded_q.pop_front()));
      end
      while (err_q.size() != 0 && err_q[0] < cyc) begin
        checks++;
        errors++;
        $display("FAIL sync_err_missing: no pulse, required at cycle %0d", err_q.pop_front());
      end
      if (sync_err) begin
        if (err_q.size() == 0) chk("sync_err_unexpected", 64'(sync_err), 64'd0);
        else chk("sync_err_cycle", 64'(cyc), 64'(err_q.pop_front()));
      end
      while (snap_q.size() != 0 && snap_q[0].cyc < cyc) begin
        checks++;
        errors++;
        sn = snap_q.pop_front();
        $display("FAIL snapshot_skipped: readback for cycle %0d never compared", sn.cyc);
      end
      if (snap_q.size() != 0 && snap_q[0].cyc == cyc) begin
        sn = snap_q.pop_front();
        for (int l = 0; l < 16; l++) begin
          rd_line = 4'(l);
          #2;
          chk($sformatf("rd_bits_line%0d", l), rd_bits, sn.lines[l]);
        end
      end
    end
  end

  // stimulus
  initial begin
    do_reset();
    idle(3);
    for (int i = 0; i < 128; i++) spr[i] = 8'(i);
    load(128, 1'b1);
    push_snap(cyc);
    idle(4);
    cycle(1'b0, 1'b0, 8'h00, 1'b1);
    idle(3);
    cycle(1'b1, 1'b0, 8'hFF, 1'b0);
    idle(2);
    rand_sprite();
    load(128, 1'b0);
    idle(2);
    cycle(1'b0, 1'b0, 8'h00, 1'b1);
    idle(3);
    rand_sprite();
    load(40, 1'b0);
    for (int i = 0; i < 128; i++) spr[i] = 8'h11;
    load(128, 1'b0);
    push_snap(cyc);
    cycle(1'b0, 1'b0, 8'h00, 1'b1);
    idle(3);
    rand_sprite();
    load(128, 1'b0);
    for (int i = 0; i < 8; i++) cycle(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 8'($urandom), 1'b0);
    do_reset();
    for (int i = 0; i < 6; i++) cycle(1'b0, 1'b0, 8'($urandom), 1'($urandom_range(0, 1)));
    rand_sprite();
    load(128, 1'b0);
    idle(2);
    cycle(1'b0, 1'b0, 8'h00, 1'b1);
    idle(4);
    chk("loaded_q_drained", 64'(loaded_q.size()), 64'd0);
    chk("err_q_drained", 64'(err_q.size()), 64'd0);
    chk("snap_q_drained", 64'(snap_q.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
